// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package mem_arb_pkg;

    // Access sequencer states; the unused 2'd3 code falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RDW  = 2'd2
    } state_t;

    // Owner of the latched command.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // Arbitration policies.
    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // The master that did not win last time.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Two-input combinational arbiter: req[0] = CPU, req[1] = DMA.
// mode = 0 alternates on ties, mode = 1 gives ties to the CPU.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_winner,
    input  logic       mode,
    output owner_t     winner,
    output logic       any
);

    // Pick the winner from the current requests and last grant.
    always_comb begin
        winner = OWN_CPU;
        any    = |req;
        case (req)
            2'b01:   winner = OWN_CPU;
            2'b10:   winner = OWN_DMA;
            2'b11:   winner = mode ? OWN_CPU : other_owner(last_winner);
            default: winner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat data-memory port between the CPU and a DMA master.
// IDLE arbitrates and latches the command, ACC drives the memory, RDW waits
// out the 1-cycle read latency before returning data to the owner.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic FIXED_PRIO = (ARB_MODE == ARB_FIXED);

    state_t        state_q, state_d;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    owner_t        lat_owner;
    owner_t        last_winner;
    owner_t        arb_winner;
    logic          arb_any;

    arb_rr2 u_arb (
        .req         ({dma_req, cpu_req}),
        .last_winner (last_winner),
        .mode        (FIXED_PRIO),
        .winner      (arb_winner),
        .any         (arb_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: one access beat, plus a wait beat for reads.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = arb_any ? ST_ACC : ST_IDLE;
            ST_ACC:  state_d = lat_we ? ST_IDLE : ST_RDW;
            ST_RDW:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch and grant history; only written at an IDLE edge with a request.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_owner   <= OWN_CPU;
            last_winner <= OWN_DMA;
        end else if (state_q == ST_IDLE && arb_any) begin
            lat_owner   <= arb_winner;
            last_winner <= arb_winner;
            if (arb_winner == OWN_CPU) begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
            end else begin
                lat_we    <= dma_we;
                lat_addr  <= dma_addr;
                lat_wdata <= dma_wdata;
            end
        end
    end

    // Read return: capture memory data on the edge leaving RDW.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= (state_q == ST_RDW) && (lat_owner == OWN_CPU);
            dma_rvalid <= (state_q == ST_RDW) && (lat_owner == OWN_DMA);
            if (state_q == ST_RDW && lat_owner == OWN_CPU) cpu_rdata <= mem_rdata;
            if (state_q == ST_RDW && lat_owner == OWN_DMA) dma_rdata <= mem_rdata;
        end
    end

    // Bus outputs decoded from state and latch only.
    always_comb begin
        mem_en    = (state_q == ST_ACC);
        mem_we    = mem_en & lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        cpu_gnt   = mem_en & (lat_owner == OWN_CPU);
        dma_gnt   = mem_en & (lat_owner == OWN_DMA);
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: transaction-level reference model with a cycle-indexed
// expectation ring, directed cases, then randomized mixed traffic.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Round-robin DUT
    logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic       mem_en, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    mem_bus_arbiter #(.AW(8), .DW(8), .ARB_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Fixed-priority DUT (write traffic only)
    logic       f_cpu_req, f_cpu_we, f_cpu_gnt, f_cpu_rvalid;
    logic [7:0] f_cpu_addr, f_cpu_wdata, f_cpu_rdata;
    logic       f_dma_req, f_dma_we, f_dma_gnt, f_dma_rvalid;
    logic [7:0] f_dma_addr, f_dma_wdata, f_dma_rdata;
    logic       f_mem_en, f_mem_we, f_busy;
    logic [7:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
    assign f_mem_rdata = '0;

    mem_bus_arbiter #(.AW(8), .DW(8), .ARB_MODE(1)) dut_fixed (
        .clk(clk), .rst(rst),
        .cpu_req(f_cpu_req), .cpu_we(f_cpu_we), .cpu_addr(f_cpu_addr), .cpu_wdata(f_cpu_wdata),
        .cpu_gnt(f_cpu_gnt), .cpu_rvalid(f_cpu_rvalid), .cpu_rdata(f_cpu_rdata),
        .dma_req(f_dma_req), .dma_we(f_dma_we), .dma_addr(f_dma_addr), .dma_wdata(f_dma_wdata),
        .dma_gnt(f_dma_gnt), .dma_rvalid(f_dma_rvalid), .dma_rdata(f_dma_rdata),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    // Memory array with 1-cycle read latency; mem_fill preloads a known pattern.
    logic       mem_fill;
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: expectations per future cycle plus held-value state.
    typedef struct {
        bit       gc, gd, en, we, bz, rvc, rvd;
        bit [7:0] addr, wdata, rdat;
    } exp_t;

    exp_t     ring [8];
    int       m_wait;
    int       m_last;            // 0 = CPU granted last, 1 = DMA
    bit [7:0] ref_mem [256];
    bit [7:0] m_cpu_rdata, m_dma_rdata, m_addr, m_wdata;

    task automatic check_cycle();
        exp_t e;
        int   idx;
        idx = cyc % 8;
        e   = ring[idx];
        ring[idx] = '{default: 0};
        if (e.en) begin
            m_addr  = e.addr;
            m_wdata = e.wdata;
        end
        if (e.rvc) m_cpu_rdata = e.rdat;
        if (e.rvd) m_dma_rdata = e.rdat;
        check_eq("cpu_gnt",    32'(cpu_gnt),    32'(e.gc));
        check_eq("dma_gnt",    32'(dma_gnt),    32'(e.gd));
        check_eq("mem_en",     32'(mem_en),     32'(e.en));
        check_eq("mem_we",     32'(mem_we),     32'(e.we));
        check_eq("we_wo_en",   32'(mem_we & ~mem_en), 32'(0));
        check_eq("busy",       32'(busy),       32'(e.bz));
        check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(e.rvc));
        check_eq("dma_rvalid", 32'(dma_rvalid), 32'(e.rvd));
        check_eq("mem_addr",   32'(mem_addr),   32'(m_addr));
        check_eq("mem_wdata",  32'(mem_wdata),  32'(m_wdata));
        check_eq("cpu_rdata",  32'(cpu_rdata),  32'(m_cpu_rdata));
        check_eq("dma_rdata",  32'(dma_rdata),  32'(m_dma_rdata));
    endtask

    // Apply the rules to the inputs present at the edge ending cycle cyc.
    task automatic model_step();
        int       win, i1, i2, i3;
        bit       we;
        bit [7:0] a, d;
        if (rst) begin
            for (int k = 0; k < 8; k++) ring[k] = '{default: 0};
            m_wait = 0; m_last = 1;
            m_cpu_rdata = '0; m_dma_rdata = '0; m_addr = '0; m_wdata = '0;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (cpu_req || dma_req) begin
            if (cpu_req && dma_req) win = (m_last == 0) ? 1 : 0;
            else                    win = cpu_req ? 0 : 1;
            we = (win == 0) ? cpu_we    : dma_we;
            a  = (win == 0) ? cpu_addr  : dma_addr;
            d  = (win == 0) ? cpu_wdata : dma_wdata;
            i1 = (cyc + 1) % 8; i2 = (cyc + 2) % 8; i3 = (cyc + 3) % 8;
            ring[i1].gc = (win == 0); ring[i1].gd = (win == 1);
            ring[i1].en = 1'b1; ring[i1].we = we; ring[i1].bz = 1'b1;
            ring[i1].addr = a; ring[i1].wdata = d;
            if (we) begin
                ref_mem[a] = d;
                m_wait = 1;
            end else begin
                ring[i2].bz = 1'b1;
                ring[i3].rvc = (win == 0); ring[i3].rvd = (win == 1);
                ring[i3].rdat = ref_mem[a];
                m_wait = 2;
            end
            m_last = win;
        end
    endtask

    task automatic tick();
        check_cycle();
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_drive();
        if (cpu_gnt) cpu_req = 1'b0;
        else if (!cpu_req && $urandom_range(0, 99) < 40) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
        end
        if (!cpu_req) begin
            cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
        end
        if (dma_gnt) dma_req = 1'b0;
        else if (!dma_req && $urandom_range(0, 99) < 40) begin
            dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
            dma_addr = 8'($urandom_range(0, 15)); dma_wdata = 8'($urandom);
        end
        if (!dma_req) begin
            dma_we = 1'($urandom_range(0, 1)); dma_addr = 8'($urandom); dma_wdata = 8'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order[$];
        int n_tx, fc, fd;
        rst = 1'b1; mem_fill = 1'b1;
        {cpu_req, cpu_we, cpu_addr, cpu_wdata} = '0;
        {dma_req, dma_we, dma_addr, dma_wdata} = '0;
        {f_cpu_req, f_cpu_we, f_cpu_addr, f_cpu_wdata} = '0;
        {f_dma_req, f_dma_we, f_dma_addr, f_dma_wdata} = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        @(negedge clk);
        model_step();
        @(negedge clk);
        cyc = 1;
        rst = 1'b0; mem_fill = 1'b0;

        // CPU write 10 <= A5: grant and strobe one cycle after the sampling edge
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        tick();
        check_eq("wr_gnt",   32'(cpu_gnt),   32'(1));
        check_eq("wr_en",    32'(mem_en),    32'(1));
        check_eq("wr_we",    32'(mem_we),    32'(1));
        check_eq("wr_addr",  32'(mem_addr),  32'(8'h10));
        check_eq("wr_wdata", 32'(mem_wdata), 32'(8'hA5));
        cpu_req = 1'b0;
        tick(); tick();

        // CPU read 10: rvalid at N+3 with A5, held afterwards
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick();
        cpu_req = 1'b0;
        tick();
        check_eq("rd_early_rvalid", 32'(cpu_rvalid), 32'(0));
        tick();
        check_eq("rd_rvalid",     32'(cpu_rvalid), 32'(1));
        check_eq("rd_rdata",      32'(cpu_rdata),  32'(8'hA5));
        check_eq("rd_dma_rvalid", 32'(dma_rvalid), 32'(0));
        tick();
        check_eq("rd_rvalid_pulse", 32'(cpu_rvalid), 32'(0));
        check_eq("rd_rdata_held",   32'(cpu_rdata),  32'(8'hA5));
        tick();

        // Random mixed traffic
        n_tx = 0;
        for (int i = 0; i < 6000 && n_tx < 1000; i++) begin
            n_tx += int'(cpu_gnt) + int'(dma_gnt);
            rand_drive();
            tick();
        end
        check_eq("rand_tx_budget", 32'(n_tx >= 1000), 32'(1));
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (4) tick();

        // DMA read aborted by reset in RDW
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h05;
        tick();
        dma_req = 1'b0;
        tick();
        check_eq("abort_busy_rdw", 32'(busy), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy",   32'(busy),       32'(0));
        check_eq("abort_rvalid", 32'(dma_rvalid), 32'(0));
        check_eq("abort_rdata",  32'(dma_rdata),  32'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("abort_no_rvalid", 32'(dma_rvalid), 32'(0));
        end

        // Round-robin with both requests held: CPU, DMA, CPU, DMA
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h01;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h21; dma_wdata = 8'h02;
        for (int i = 0; i < 20 && order.size() < 4; i++) begin
            tick();
            if (cpu_gnt) order.push_back(0);
            if (dma_gnt) order.push_back(1);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check_eq("rr_count", 32'(order.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) check_eq("rr_order", 32'(order[i]), 32'(i % 2));
        end
        tick(); tick();

        // Command change during ACC ignored; held req re-granted 2 cycles later
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h11;
        tick();
        cpu_addr = 8'h31; cpu_wdata = 8'h22;
        check_eq("acc_gnt",  32'(cpu_gnt),  32'(1));
        check_eq("acc_addr", 32'(mem_addr), 32'(8'h30));
        tick();
        check_eq("idle_no_gnt", 32'(cpu_gnt), 32'(0));
        tick();
        check_eq("regrant_gnt",   32'(cpu_gnt),   32'(1));
        check_eq("regrant_addr",  32'(mem_addr),  32'(8'h31));
        check_eq("regrant_wdata", 32'(mem_wdata), 32'(8'h22));
        cpu_req = 1'b0;
        tick(); tick();

        // Fixed priority: CPU wins every tie while held
        f_cpu_req = 1'b1; f_cpu_we = 1'b1; f_cpu_addr = 8'h40; f_cpu_wdata = 8'h33;
        f_dma_req = 1'b1; f_dma_we = 1'b1; f_dma_addr = 8'h41; f_dma_wdata = 8'h44;
        fc = 0; fd = 0;
        for (int i = 0; i < 20 && fc < 4; i++) begin
            @(negedge clk);
            fc += int'(f_cpu_gnt);
            fd += int'(f_dma_gnt);
        end
        f_cpu_req = 1'b0;
        check_eq("fixed_cpu_grants", 32'(fc), 32'(4));
        check_eq("fixed_dma_grants", 32'(fd), 32'(0));
        fd = 0;
        for (int i = 0; i < 6 && fd == 0; i++) begin
            @(negedge clk);
            fd += int'(f_dma_gnt);
        end
        f_dma_req = 1'b0;
        check_eq("fixed_dma_served", 32'(fd), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
